// File: rtl/cmutex_pkg.sv
// cmutex_pkg: shared FSM state and width helper for the cmutex merge family.
package cmutex_pkg;
    typedef enum logic {S_IDLE, S_BUSY} state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: combinational round-robin pick of the first request at or above ptr, wrapping modulo N.
module rr_arbiter_n
    import cmutex_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);
    logic hit;
    int   j;
    always_comb begin
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        j   = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!hit && req[j]) begin
                gnt[j] = 1'b1;
                idx    = IW'(j);
                hit    = 1'b1;
            end
        end
    end
    assign valid = |req;
endmodule

// File: rtl/cmutex_merge_n.sv
// cmutex_merge_n: N-way mutually exclusive merge with data; latches drives,
// grants round-robin, and returns a free only to the owning channel.
module cmutex_merge_n
    import cmutex_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 32,
    localparam int IW = idx_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    i_drive,
    input  logic [N*DW-1:0] i_data,
    output logic [N-1:0]    o_free,
    output logic            o_driveNext,
    output logic [DW-1:0]   o_data,
    input  logic            i_freeNext,
    output logic [IW-1:0]   o_owner,
    output logic            o_busy,
    output logic            o_err
);
    state_t          state;
    logic [N-1:0]    pend, clr, drive_ok, gnt;
    logic [DW-1:0]   dreg [N];
    logic [DW-1:0]   gdata;
    logic [IW-1:0]   ptr, gidx;
    logic            gvalid, release_ev, drive_err, free_err;

    rr_arbiter_n #(.N(N)) u_arb (
        .req   (pend),
        .ptr   (ptr),
        .gnt   (gnt),
        .idx   (gidx),
        .valid (gvalid)
    );

    // A drive on the owner in the release cycle is re-entry, not a collision.
    assign release_ev = (state == S_BUSY) && i_freeNext;
    assign clr        = release_ev ? ({{(N-1){1'b0}}, 1'b1} << o_owner) : '0;
    assign drive_ok   = i_drive & (~pend | clr);
    assign drive_err  = |(i_drive & pend & ~clr);
    assign free_err   = (state == S_IDLE) && i_freeNext;

    always_comb begin
        gdata = '0;
        for (int k = 0; k < N; k++)
            gdata = gdata | (dreg[k] & {DW{gnt[k]}});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pend        <= '0;
            ptr         <= '0;
            o_owner     <= '0;
            o_data      <= '0;
            o_busy      <= 1'b0;
            o_driveNext <= 1'b0;
            o_free      <= '0;
            o_err       <= 1'b0;
            for (int k = 0; k < N; k++)
                dreg[k] <= '0;
        end else begin
            o_driveNext <= 1'b0;
            o_free      <= '0;
            pend        <= (pend & ~clr) | drive_ok;
            for (int k = 0; k < N; k++)
                if (drive_ok[k])
                    dreg[k] <= i_data[k*DW +: DW];
            if (drive_err || free_err)
                o_err <= 1'b1;
            if (state == S_IDLE) begin
                if (gvalid) begin
                    state       <= S_BUSY;
                    o_owner     <= gidx;
                    o_data      <= gdata;
                    o_driveNext <= 1'b1;
                    o_busy      <= 1'b1;
                end
            end else if (i_freeNext) begin
                state  <= S_IDLE;
                o_busy <= 1'b0;
                o_free <= clr;
                ptr    <= (o_owner == IW'(N-1)) ? '0 : o_owner + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cmutex_merge_n.sv
// tb_cmutex_merge_n: scoreboard bench; expected grants are queued at stimulus time
// and popped by a monitor on every downstream drive.
module tb_cmutex_merge_n;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    i_drive;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]    o_free;
    logic            o_driveNext;
    logic [DW-1:0]   o_data;
    logic            i_freeNext;
    logic [IW-1:0]   o_owner;
    logic            o_busy;
    logic            o_err;

    cmutex_merge_n #(.N(N), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (i_drive),
        .i_data      (i_data),
        .o_free      (o_free),
        .o_driveNext (o_driveNext),
        .o_data      (o_data),
        .i_freeNext  (i_freeNext),
        .o_owner     (o_owner),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    typedef struct { int owner; logic [DW-1:0] data; } exp_t;
    exp_t exp_q[$];
    exp_t cur_e;
    int   n_chk = 0, n_pass = 0, n_drv = 0, n_free = 0, cur = 0;
    bit   armed = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic push(input int o, input logic [DW-1:0] d);
        exp_t e;
        e.owner = o;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every downstream drive must match the next queued grant; every
    // free must go to the owner of the transaction it closes.
    always @(negedge clk) begin
        if (!rst) armed = 0;
        else begin
            if (o_driveNext) begin
                n_drv++;
                if (exp_q.size() == 0) chk("drv_unexpected", 1, 0);
                else begin
                    cur_e = exp_q.pop_front();
                    chk("owner", 64'(o_owner), 64'(cur_e.owner));
                    chk("data", 64'(o_data), 64'(cur_e.data));
                    chk("busy_at_drv", 64'(o_busy), 1);
                    cur   = cur_e.owner;
                    armed = 1;
                end
            end
            if (o_free != 0) begin
                n_free++;
                chk("free_vec", 64'(o_free), armed ? (64'd1 << cur) : 64'd0);
                chk("busy_at_free", 64'(o_busy), 0);
                armed = 0;
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_drv"}, 64'(o_driveNext), 0);
        chk({tag, "_free"}, 64'(o_free), 0);
        chk({tag, "_busy"}, 64'(o_busy), 0);
        chk({tag, "_owner"}, 64'(o_owner), 0);
        chk({tag, "_data"}, 64'(o_data), 0);
        chk({tag, "_err"}, 64'(o_err), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        #1 chk_zero(tag);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_drv();
        int t = 0;
        while (!o_driveNext && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (!o_driveNext) chk("drv_timeout", 0, 1);
    endtask

    // Waits for the downstream drive, answers after d cycles, optionally re-driving channel k in the release cycle.
    task automatic serve_rd(input int d, input int k, input logic [DW-1:0] v);
        wait_drv();
        repeat (d) @(negedge clk);
        i_freeNext = 1'b1;
        if (k >= 0) begin
            i_drive[k]          = 1'b1;
            i_data[k*DW +: DW]  = v;
        end
        @(negedge clk);
        i_freeNext = 1'b0;
        i_drive    = '0;
    endtask

    task automatic serve(input int d);
        serve_rd(d, -1, '0);
    endtask

    int d0, f0, own;

    initial begin
        rst = 1'b0; i_drive = '0; i_data = '0; i_freeNext = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("rst0");
        rst = 1'b1;

        // Single request with exact latencies
        @(negedge clk);
        i_drive = 4'b0100; i_data[2*DW +: DW] = 32'hA5; push(2, 32'hA5);
        @(negedge clk);
        i_drive = '0;
        chk("lat_c1", 64'(o_driveNext), 0);
        @(negedge clk);
        chk("lat_c2", 64'(o_driveNext), 1);
        repeat (3) @(negedge clk);
        chk("busy_c5", 64'(o_busy), 1);
        chk("owner_hold", 64'(o_owner), 2);
        i_freeNext = 1'b1;
        @(negedge clk);
        i_freeNext = 1'b0;
        chk("free_c6", 64'(o_free), 4'b0100);
        @(negedge clk);
        chk("free_c7", 64'(o_free), 0);

        // Simultaneous requests 1011 from ptr=0
        do_reset("rst1");
        d0 = n_drv; f0 = n_free;
        @(negedge clk);
        i_drive = 4'b1011;
        i_data  = {32'hD3, 32'h0, 32'hD1, 32'hD0};
        push(0, 32'hD0); push(1, 32'hD1); push(3, 32'hD3);
        @(negedge clk);
        i_drive = '0;
        repeat (3) serve(1);
        repeat (4) @(negedge clk);
        chk("simul_drv_cnt", 64'(n_drv - d0), 3);
        chk("simul_free_cnt", 64'(n_free - f0), 3);

        // Fairness: ch0 and ch3 re-drive at each release
        i_drive = 4'b1001;
        i_data[0 +: DW]    = 32'hF000_0000;
        i_data[3*DW +: DW] = 32'hF000_0001;
        push(0, 32'hF000_0000); push(3, 32'hF000_0001);
        @(negedge clk);
        i_drive = '0;
        for (int j = 0; j < 20; j++) begin
            own = (j % 2 == 0) ? 0 : 3;
            if (j + 2 < 20) begin
                push(own, 32'hF000_0000 + 32'(j + 2));
                serve_rd(1, own, 32'hF000_0000 + 32'(j + 2));
            end else serve(1);
        end
        repeat (3) @(negedge clk);
        chk("fair_err", 64'(o_err), 0);
        chk("fair_q_empty", 64'(exp_q.size()), 0);

        // Re-entry of owner 1 in its release cycle
        i_drive = 4'b0010; i_data[DW +: DW] = 32'h1111; push(1, 32'h1111);
        @(negedge clk);
        i_drive = '0;
        push(1, 32'h2222);
        serve_rd(2, 1, 32'h2222);
        chk("reentry_err", 64'(o_err), 0);
        serve(0);
        repeat (3) @(negedge clk);
        chk("reentry_err2", 64'(o_err), 0);

        // Duplicate drive while pending: dropped, first data kept
        i_drive = 4'b0001; i_data[0 +: DW] = 32'hE1; push(0, 32'hE1);
        @(negedge clk);
        i_data[0 +: DW] = 32'hE2;
        @(negedge clk);
        i_drive = '0;
        chk("dup_err", 64'(o_err), 1);
        serve(2);
        repeat (3) @(negedge clk);
        chk("dup_err_sticky", 64'(o_err), 1);

        // Free while idle: error only, no spurious events
        do_reset("rst2");
        d0 = n_drv; f0 = n_free;
        i_freeNext = 1'b1;
        @(negedge clk);
        i_freeNext = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_free_err", 64'(o_err), 1);
        chk("idle_free_drv", 64'(n_drv - d0), 0);
        chk("idle_free_free", 64'(n_free - f0), 0);
        i_drive = 4'b0100; i_data[2*DW +: DW] = 32'h77; push(2, 32'h77);
        @(negedge clk);
        i_drive = '0;
        serve(1);
        chk("err_sticky", 64'(o_err), 1);

        // Reset while busy with owner 2
        i_drive = 4'b0100; i_data[2*DW +: DW] = 32'h5A; push(2, 32'h5A);
        @(negedge clk);
        i_drive = '0;
        wait_drv();
        f0 = n_free;
        do_reset("rst_busy");
        repeat (4) @(negedge clk);
        chk("no_abort_free", 64'(n_free - f0), 0);
        i_drive = 4'b1001;
        i_data[0 +: DW]    = 32'hC0;
        i_data[3*DW +: DW] = 32'hC3;
        push(0, 32'hC0); push(3, 32'hC3);
        @(negedge clk);
        i_drive = '0;
        serve(0);
        serve(0);
        i_drive = 4'b1000; i_data[3*DW +: DW] = 32'hC4; push(3, 32'hC4);
        @(negedge clk);
        i_drive = '0;
        serve(1);
        repeat (3) @(negedge clk);
        chk("post_rst_err", 64'(o_err), 0);
        chk("final_q_empty", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/cmutex_merge_n.md
# cmutex_merge_n

Clocked N-way mutually exclusive merge with data. It collects single-cycle drive events from N upstream channels and forwards exactly one at a time to a single downstream consumer, choosing among simultaneous requests round-robin. It returns a free event only to the owning channel, and only after the downstream free arrives. It is the parametrised successor of the two-input control-only merge in the pipeline-joint library: it adds N-way fan-in, a data path, request latching, fair arbitration and protocol-error reporting.

## Interface
- N, default 4: number of input channels, 2..16.
- DW, default 32: data width carried with each drive; 1..256.
- IW, localparam, $clog2(N): owner index width.
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-low reset.
- i_drive  in  N: per-channel drive event, one-cycle pulse.
- i_data  in  N*DW: channel k data in slice [k*DW +: DW], valid in the cycle i_drive[k] is high.
- o_free  out  N: per-channel free event, one-cycle pulse.
- o_driveNext  out  1: downstream drive event, one-cycle pulse.
- o_data  out  DW: owner's data, valid from the o_driveNext cycle until o_free is issued.
- i_freeNext  in  1: downstream free event, one-cycle pulse.
- o_owner  out  IW: index of the current owner, valid while o_busy is high.
- o_busy  out  1: a transaction is outstanding downstream.
- o_err  out  1: sticky protocol-error flag, cleared only by reset.

## Operation
- Per-channel pend[k] bit and data register.
  - i_drive[k] sampled high sets pend[k] and captures that channel's data.
- FSM has two states.
  - IDLE: if any pend bit is set, grant g = the first set pend bit searching upward from ptr and wrapping modulo N. Latch the owner as g and o_data as data[g], then go to BUSY.
  - BUSY: wait for i_freeNext.
    - On i_freeNext: clear pend[owner], set ptr = (owner+1) mod N, then return to IDLE.
- Round-robin pointer ptr resets to 0, so channel 0 wins the first simultaneous contest.
- Entry to BUSY produces a one-cycle o_driveNext pulse.
- i_freeNext in BUSY produces a one-cycle o_free[owner] pulse. No other channel ever receives a free.
- Error cases: each sets o_err; none changes FSM state.
  - i_drive[k] while pend[k] is already set and not being cleared in the same cycle. The event is dropped and the stored data is kept.
  - i_freeNext while in IDLE. It is ignored.
- i_drive[owner] in the same cycle as the accepted i_freeNext is legal re-entry. pend stays set with the new data and no error is raised. That channel is lowest priority in the next arbitration.
- Drives on non-owner channels during BUSY are queued in pend and served after release. They are not errors.

## Timing
- Reset values: o_driveNext=0, o_free=0, o_busy=0, o_owner=0, o_data=0, o_err=0, all pend=0, ptr=0, FSM=IDLE. All outputs are registered.
- Latency from drive to downstream drive: 2 cycles.
  - i_drive[k] high in cycle c sets pend at the end of c.
  - The grant is taken at the end of c+1, so o_driveNext is high in cycle c+2, provided the FSM was IDLE in c+1.
- Latency from downstream free to upstream free: 1 cycle. i_freeNext high in cycle f gives o_free[owner] high in f+1, and o_busy is low from f+1.
- Earliest next o_driveNext is f+2. There is at least one idle cycle between transactions.
- o_busy rises with o_driveNext. o_owner and o_data are stable for the whole BUSY period.
- i_freeNext in the same cycle as o_driveNext is accepted; the downstream response takes a minimum of 0 cycles.
- Reset asserted mid-transaction: all state clears immediately, and no o_free is issued for the aborted transaction.

## Structure
- Shared package cmutex_pkg: localparam width helper and the FSM state enum (S_IDLE, S_BUSY).
- Sub-module rr_arbiter_n (N, request vector, pointer in → one-hot grant plus index, combinational). It is reused by future N-way select blocks.
- The top level holds the pend/data registers, the FSM, the pointer and the output registers.

## Test plan
- Single request: N=4, i_drive[2] pulse with data 0xA5 at cycle 0. Required: o_driveNext at cycle 2 with o_data=0xA5 and o_owner=2. i_freeNext at cycle 5 gives o_free=4'b0100 at cycle 6, and no other o_free.
- Simultaneous requests: i_drive=4'b1011 in one cycle. Grants go in order 0, 1, 3, each released by i_freeNext. Exactly three o_driveNext and three o_free pulses.
- Fairness: ch0 and ch3 re-drive immediately after each free for 20 transactions. Owners alternate 0, 3, 0, 3, and ch0 never wins twice in a row.
- Re-entry: i_drive[1] in the same cycle as the i_freeNext releasing owner 1. o_free[1] pulses, o_err stays 0, and the new data is issued later.
- Errors: a second i_drive[0] while pend[0] is set, and i_freeNext while IDLE. o_err goes to 1 and stays, the first data is preserved, and no spurious o_driveNext or o_free occurs.
- Reset in BUSY: rst low for 2 cycles while owner=2. All outputs are 0, no o_free[2] is issued, and after reset a fresh i_drive[3] is served normally with ptr=0.
